// File: rtl/hdmi_rx_capture_if.sv
// Video-in and frame-memory write bundle for hdmi_rx_capture.
// slave is the capture block, master is the video source / memory side.
interface hdmi_rx_capture_if #(
    parameter int ADDR_W = 20
);
    logic [23:0]       In_pData;
    logic              In_pVSync;
    logic              In_pHSync;
    logic              In_pVDE;
    logic              Mem_Write;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [23:0]       Mem_Data;

    modport master (
        output In_pData,
        output In_pVSync,
        output In_pHSync,
        output In_pVDE,
        input  Mem_Write,
        input  Mem_Addr,
        input  Mem_Data
    );

    modport slave (
        input  In_pData,
        input  In_pVSync,
        input  In_pHSync,
        input  In_pVDE,
        output Mem_Write,
        output Mem_Addr,
        output Mem_Data
    );
endinterface

// File: rtl/hdmi_rx_capture.sv
// 640x480 receive capture: geometry check, linear frame-memory writes,
// per-frame status and FraimSync parity for the transmit path.
module hdmi_rx_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 20
) (
    input  logic             clk,
    input  logic             rstn,
    hdmi_rx_capture_if.slave vid,
    output logic             FraimSync,
    output logic             Frame_Done,
    output logic             Frame_Err,
    output logic             Locked,
    output logic [15:0]      Line_counter
);

    typedef enum logic [1:0] {
        WAIT_VS,
        WAIT_DE,
        ACTIVE
    } state_t;

    localparam logic [9:0]  H_L = 10'(H_ACTIVE);
    localparam logic [15:0] V_L = 16'(V_ACTIVE);

    state_t            state;
    logic [23:0]       r_data;
    logic              r_vs;
    logic              r_hs;
    logic              r_de;
    logic              p_vs;
    logic              p_de;
    logic [9:0]        pix;
    logic [ADDR_W-1:0] addr;
    logic              err_seen;

    logic              vs_fall;
    logic              de_rise;
    logic              de_fall;
    logic [9:0]        pix_cur;
    logic              in_frame;
    logic              accept;
    logic              line_err;
    logic              eof_err;
    logic              unused_hs;

    assign unused_hs = r_hs;

    // Sync idles high, so reset the history high to avoid a fake fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
            r_vs   <= 1'b1;
            r_hs   <= 1'b1;
            r_de   <= 1'b0;
            p_vs   <= 1'b1;
            p_de   <= 1'b0;
        end else begin
            r_data <= vid.In_pData;
            r_vs   <= vid.In_pVSync;
            r_hs   <= vid.In_pHSync;
            r_de   <= vid.In_pVDE;
            p_vs   <= r_vs;
            p_de   <= r_de;
        end
    end

    assign vs_fall = p_vs & ~r_vs;
    assign de_rise = r_de & ~p_de;
    assign de_fall = p_de & ~r_de;

    // The DE_rise cycle already carries pixel 0 of the line.
    assign pix_cur  = de_rise ? '0 : pix;
    assign in_frame = (state == ACTIVE) ||
                      (state == WAIT_DE && de_rise);
    assign accept   = r_de && in_frame && !vs_fall &&
                      (pix_cur < H_L) &&
                      (Line_counter < V_L);
    assign line_err = de_fall && (pix != H_L);
    assign eof_err  = r_de || (Line_counter != V_L) ||
                      line_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= WAIT_VS;
            pix           <= '0;
            addr          <= '0;
            err_seen      <= 1'b0;
            vid.Mem_Write <= 1'b0;
            vid.Mem_Addr  <= '0;
            vid.Mem_Data  <= '0;
            FraimSync     <= 1'b0;
            Frame_Done    <= 1'b0;
            Frame_Err     <= 1'b0;
            Locked        <= 1'b0;
            Line_counter  <= '0;
        end else begin
            vid.Mem_Write <= accept;
            vid.Mem_Data  <= r_data;
            Frame_Done    <= 1'b0;
            Frame_Err     <= 1'b0;
            if (accept) begin
                vid.Mem_Addr <= addr;
                addr         <= addr + 1'b1;
            end
            if (r_de && pix_cur != '1)
                pix <= pix_cur + 10'd1;
            else if (de_rise)
                pix <= pix_cur;
            unique case (state)
                WAIT_VS: begin
                    if (vs_fall) begin
                        state        <= WAIT_DE;
                        addr         <= '0;
                        pix          <= '0;
                        Line_counter <= '0;
                        err_seen     <= 1'b0;
                    end
                end
                WAIT_DE: begin
                    if (vs_fall) begin
                        addr         <= '0;
                        pix          <= '0;
                        Line_counter <= '0;
                        err_seen     <= 1'b0;
                    end else if (de_rise) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (vs_fall) begin
                        state        <= WAIT_DE;
                        addr         <= '0;
                        pix          <= '0;
                        Line_counter <= '0;
                        err_seen     <= 1'b0;
                        if (eof_err) begin
                            Frame_Err <= 1'b1;
                            Locked    <= 1'b0;
                        end else if (!err_seen) begin
                            Frame_Done <= 1'b1;
                            FraimSync  <= ~FraimSync;
                            Locked     <= 1'b1;
                        end
                    end else if (de_fall) begin
                        if (Line_counter != '1)
                            Line_counter <= Line_counter + 16'd1;
                        if (line_err) begin
                            Frame_Err <= 1'b1;
                            Locked    <= 1'b0;
                            err_seen  <= 1'b1;
                        end
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_rx_capture.sv
// Scoreboard bench for hdmi_rx_capture on a reduced 8x4 active area.
// Stimulus pushes expected writes/status pulses; a monitor pops them.
module tb_hdmi_rx_capture;

    localparam int H = 8;
    localparam int V = 4;
    localparam int AW = 20;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
        logic [31:0]   cyc;
    } wr_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic        fsync;
        logic        locked;
        logic [31:0] cyc;
    } ev_t;

    logic        clk;
    logic        rstn;
    logic        FraimSync;
    logic        Frame_Done;
    logic        Frame_Err;
    logic        Locked;
    logic [15:0] Line_counter;
    logic [31:0] cyc = '0;

    int checks = 0;
    int failures = 0;

    wr_t wq[$];
    ev_t eq[$];

    bit m_started;
    bit m_active;
    bit m_err;
    bit m_fsync;
    bit m_locked;
    int m_lines;
    int m_addr;
    int frame_no;

    hdmi_rx_capture_if #(.ADDR_W(AW)) bus ();

    hdmi_rx_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .vid         (bus),
        .FraimSync   (FraimSync),
        .Frame_Done  (Frame_Done),
        .Frame_Err   (Frame_Err),
        .Locked      (Locked),
        .Line_counter(Line_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.Mem_Write) begin
                wr_t a;
                wr_t e;
                a.addr = bus.Mem_Addr;
                a.data = bus.Mem_Data;
                a.cyc  = cyc;
                checks++;
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected got addr=%0d data=%h",
                             a.addr, a.data);
                end else begin
                    e = wq.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL write got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                                 a.addr, a.data, a.cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (Frame_Done || Frame_Err) begin
                ev_t a;
                ev_t e;
                a.kind   = {Frame_Err, Frame_Done};
                a.fsync  = FraimSync;
                a.locked = Locked;
                a.cyc    = cyc;
                checks++;
                if (eq.size() == 0) begin
                    failures++;
                    $display("FAIL status_unexpected got kind=%0d cyc=%0d",
                             a.kind, a.cyc);
                end else begin
                    e = eq.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL status got kind=%0d fsync=%0d locked=%0d cyc=%0d required kind=%0d fsync=%0d locked=%0d cyc=%0d",
                                 a.kind, a.fsync, a.locked, a.cyc,
                                 e.kind, e.fsync, e.locked, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_mem_write"}, 32'(bus.Mem_Write), 0);
        chk({tag, "_mem_addr"}, 32'(bus.Mem_Addr), 0);
        chk({tag, "_mem_data"}, 32'(bus.Mem_Data), 0);
        chk({tag, "_fsync"}, 32'(FraimSync), 0);
        chk({tag, "_done"}, 32'(Frame_Done), 0);
        chk({tag, "_err"}, 32'(Frame_Err), 0);
        chk({tag, "_locked"}, 32'(Locked), 0);
        chk({tag, "_line_cnt"}, 32'(Line_counter), 0);
    endtask

    // Status pulses land two cycles after the input edge that causes them.
    task automatic push_ev(input logic [1:0] k);
        ev_t e;
        e.kind   = k;
        e.fsync  = m_fsync;
        e.locked = m_locked;
        e.cyc    = cyc + 2;
        eq.push_back(e);
    endtask

    task automatic vs_fall(input bit de_hold);
        if (m_active) begin
            if (de_hold || m_lines != V) begin
                m_locked = 0;
                push_ev(2'd2);
            end else if (!m_err) begin
                m_fsync  = ~m_fsync;
                m_locked = 1;
                push_ev(2'd1);
            end
        end
        m_started = 1;
        m_active  = 0;
        m_lines   = 0;
        m_addr    = 0;
        m_err     = 0;
        frame_no++;
        bus.In_pVSync = 1'b0;
        tick();
        bus.In_pVDE = 1'b0;
        tick();
        tick();
        bus.In_pVSync = 1'b1;
        tick();
        tick();
    endtask

    task automatic pixels(input int n);
        bus.In_pHSync = 1'b0;
        tick();
        tick();
        bus.In_pHSync = 1'b1;
        tick();
        tick();
        for (int p = 0; p < n; p++) begin
            wr_t w;
            logic [23:0] d;
            d = {8'(frame_no), 8'(m_lines), 8'(p)};
            if (p == 0 && m_started) m_active = 1;
            bus.In_pVDE  = 1'b1;
            bus.In_pData = d;
            if (m_started && p < H && m_lines < V) begin
                w.addr = AW'(m_addr);
                w.data = d;
                w.cyc  = cyc + 2;
                wq.push_back(w);
                m_addr++;
            end
            tick();
        end
    endtask

    task automatic line(input int n);
        pixels(n);
        bus.In_pVDE = 1'b0;
        if (m_active) begin
            m_lines++;
            if (n != H) begin
                m_err    = 1;
                m_locked = 0;
                push_ev(2'd2);
            end
        end
        tick();
        tick();
        chk("line_cnt", 32'(Line_counter), 32'(m_lines));
    endtask

    task automatic frame(input int nl, input int sh_line,
                         input int sh_n);
        vs_fall(1'b0);
        tick();
        tick();
        tick();
        for (int l = 0; l < nl; l++)
            line(l == sh_line ? sh_n : H);
    endtask

    initial begin
        m_started = 0;
        m_active  = 0;
        m_err     = 0;
        m_fsync   = 0;
        m_locked  = 0;
        m_lines   = 0;
        m_addr    = 0;
        frame_no  = 0;
        rstn          = 1'b0;
        bus.In_pData  = '0;
        bus.In_pVSync = 1'b1;
        bus.In_pHSync = 1'b1;
        bus.In_pVDE   = 1'b0;
        tick();
        tick();
        tick();
        chk_reset_outs("reset");
        rstn = 1'b1;
        tick();

        // VDE before any VSync fall must be ignored
        line(H);
        line(H);

        frame(V, -1, 0);
        frame(V, 1, H - 1);
        frame(V, 0, H + 1);
        frame(V, -1, 0);

        // VSync falls mid-line with VDE high
        vs_fall(1'b0);
        tick();
        line(H);
        line(H);
        pixels(3);
        vs_fall(1'b1);

        frame(V, -1, 0);

        // reset in the middle of a line
        vs_fall(1'b0);
        tick();
        line(H);
        line(H);
        pixels(4);
        rstn = 1'b0;
        #1;
        chk_reset_outs("midreset");
        m_started = 0;
        m_active  = 0;
        m_err     = 0;
        m_fsync   = 0;
        m_locked  = 0;
        m_lines   = 0;
        m_addr    = 0;
        wq.delete();
        tick();
        tick();
        rstn = 1'b1;
        for (int p = 0; p < 4; p++) tick();
        bus.In_pVDE = 1'b0;
        tick();
        tick();
        line(H);

        frame(V, -1, 0);
        frame(V + 1, -1, 0);
        vs_fall(1'b0);

        for (int i = 0; i < 10; i++) tick();
        chk("writes_drained", 32'(wq.size()), 0);
        chk("status_drained", 32'(eq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
